// File: rtl/sevenseg_if.sv
// Scanned seven-segment display lines plus the digit values recovered from them.
// Latency: none, this only bundles wires.
// Backpressure: none, the display scan is free-running and cannot be stalled.
interface sevenseg_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              sevenseg_n;
    logic [NUM_DIGITS-1:0]   digit_sel_n;
    logic [4*NUM_DIGITS-1:0] bcd_digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    frame_done;
    logic                    seg_err;

    // Display driver side: drives the scan lines and observes the recovered digits.
    modport master (
        output sevenseg_n, digit_sel_n,
        input  bcd_digits, digit_valid, frame_done, seg_err
    );

    // Reader side: watches the scan lines and produces the recovered digits.
    modport slave (
        input  sevenseg_n, digit_sel_n,
        output bcd_digits, digit_valid, frame_done, seg_err
    );
endinterface

// File: rtl/sevenseg_reader.sv
// Recovers BCD digits from a multiplexed, active-low seven-segment scan (readback monitor).
// Latency: a strobe stable from edge k is committed after edge k+STABLE_CYCLES.
// Backpressure: none; strobes shorter than STABLE_CYCLES samples are silently dropped.
module sevenseg_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    sevenseg_if.slave  bus
);
    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    // {legal, value}; blank (all segments off) is a legal pattern that reads as 4'hF.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode = {1'b1, 4'h0};
            7'h06:   decode = {1'b1, 4'h1};
            7'h5B:   decode = {1'b1, 4'h2};
            7'h4F:   decode = {1'b1, 4'h3};
            7'h66:   decode = {1'b1, 4'h4};
            7'h6D:   decode = {1'b1, 4'h5};
            7'h7D:   decode = {1'b1, 4'h6};
            7'h07:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h6F:   decode = {1'b1, 4'h9};
            7'h00:   decode = {1'b1, 4'hF};
            default: decode = {1'b0, 4'hF};
        endcase
    endfunction

    state_t                  state_q, state_nxt;
    logic [CW-1:0]           cnt_q, cnt_nxt, cnt_inc;
    logic [6:0]              samp_seg, cand_seg;
    logic [NUM_DIGITS-1:0]   samp_sel, cand_sel;
    logic [NUM_DIGITS-1:0]   sel_oh, seen_q, seen_nxt;
    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic                    frame_done_q, seg_err_q;
    logic                    is_onehot, match, start_cand, load_cand, commit;
    logic [4:0]              dec;

    assign sel_oh    = ~samp_sel;
    assign is_onehot = $onehot(sel_oh);
    assign match     = (samp_sel == cand_sel) && (samp_seg == cand_seg);
    assign cnt_inc   = cnt_q + CW'(1);
    assign dec       = decode(~samp_seg);
    assign seen_nxt  = seen_q | sel_oh;

    assign bus.bcd_digits  = bcd_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.seg_err     = seg_err_q;

    // Register the asynchronous display lines before anything looks at them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_seg <= '1;
            samp_sel <= '1;
        end else begin
            samp_seg <= bus.sevenseg_n;
            samp_sel <= bus.digit_sel_n;
        end
    end

    // State, stability counter and the candidate (select, segments) being qualified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cand_seg <= '0;
            cand_sel <= '1;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            if (load_cand) begin
                cand_seg <= samp_seg;
                cand_sel <= samp_sel;
            end
        end
    end

    // Next state: qualify each one-hot strobe for STABLE_CYCLES samples, commit it once.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        start_cand = 1'b0;
        load_cand  = 1'b0;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_nxt = '0;
                if (is_onehot) start_cand = 1'b1;
            end
            SETTLE: begin
                if (!is_onehot) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (match) begin
                    if (cnt_inc >= CNT_MAX) begin
                        commit    = 1'b1;
                        state_nxt = LOCKED;
                        cnt_nxt   = CNT_MAX;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    start_cand = 1'b1;
                end
            end
            LOCKED: begin
                if (!is_onehot) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (!match) begin
                    start_cand = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // A new strobe counts as its first stable sample; with a one-sample
        // threshold that sample alone is enough to commit.
        if (start_cand) begin
            load_cand = 1'b1;
            cnt_nxt   = CW'(1);
            if (STABLE_CYCLES == 1) begin
                commit    = 1'b1;
                state_nxt = LOCKED;
            end else begin
                state_nxt = SETTLE;
            end
        end
    end

    // Commit the strobed digit, flag illegal patterns and track frame completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q        <= '1;
            valid_q      <= '0;
            seen_q       <= '0;
            frame_done_q <= 1'b0;
            seg_err_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            seg_err_q    <= 1'b0;
            if (commit) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_oh[i]) begin
                        valid_q[i] <= dec[4];
                        if (dec[4]) bcd_q[4*i +: 4] <= dec[3:0];
                    end
                end
                seg_err_q <= ~dec[4];
                if (&seen_nxt) begin
                    frame_done_q <= 1'b1;
                    seen_q       <= '0;
                end else begin
                    seen_q <= seen_nxt;
                end
            end
        end
    end
endmodule
